dm_arbiter: RTL and testbench

Data-memory access controller and arbiter that sits between the MEM stage of the pipeline and the single-ported data memory whose read data feeds the DM/WB pipeline register. It shares the memory between the pipeline and a loader/debug port, sequences each multi-cycle access, and stalls the pipeline until the access completes. Requests are arbitrated by alternating priority, so neither side can starve the other.

---
 rtl/dm_arbiter.sv | 136 +++++++++++++
 tb/tb_dm_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares a single-ported data memory between the MEM stage and a
// loader/debug port. Each access is sequenced IDLE -> ISSUE -> WAIT -> DONE,
// and the pipeline is stalled until its own access reaches DONE. When both
// sides request together, priority alternates so neither side can starve.
module dm_arbiter #(
    parameter int DSIZE = 16,
    parameter int MSIZE = 8,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_req,
    input  logic             p_we,
    input  logic [MSIZE-1:0] p_addr,
    input  logic [DSIZE-1:0] p_wdata,
    output logic [DSIZE-1:0] p_rdata,
    output logic             p_stall,
    input  logic             l_req,
    input  logic             l_we,
    input  logic [MSIZE-1:0] l_addr,
    input  logic [DSIZE-1:0] l_wdata,
    output logic [DSIZE-1:0] l_rdata,
    output logic             l_ack,
    output logic             dm_en,
    output logic             dm_we,
    output logic [MSIZE-1:0] dm_addr,
    output logic [DSIZE-1:0] dm_wdata,
    input  logic [DSIZE-1:0] dm_rdata
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWN_PIPE, OWN_LDR} owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, last_q, grant;
    logic [CW-1:0]    cnt_q;
    logic             we_q;
    logic [MSIZE-1:0] addr_q;
    logic [DSIZE-1:0] wdata_q;
    logic [DSIZE-1:0] p_rdata_q;
    logic [DSIZE-1:0] l_rdata_q;
    logic             p_done;

    // Alternating priority: the loader wins a tie only if the pipeline was served last.
    always_comb begin
        grant = OWN_PIPE;
        if (l_req && (!p_req || last_q == OWN_PIPE)) begin
            grant = OWN_LDR;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only sampled in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (p_req || l_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access datapath: latch the granted request, count latency, capture load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_PIPE;
            last_q    <= OWN_LDR;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            p_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p_req || l_req) begin
                        owner_q <= grant;
                        if (grant == OWN_LDR) begin
                            we_q    <= l_we;
                            addr_q  <= l_addr;
                            wdata_q <= l_wdata;
                        end else begin
                            we_q    <= p_we;
                            addr_q  <= p_addr;
                            wdata_q <= p_wdata;
                        end
                    end
                end
                ISSUE: cnt_q <= CW'(LAT - 1);
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (!we_q) begin
                            if (owner_q == OWN_PIPE) begin
                                p_rdata_q <= dm_rdata;
                            end else begin
                                l_rdata_q <= dm_rdata;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: last_q <= owner_q;
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state and latched request.
    always_comb begin
        dm_en   = (state_q == ISSUE);
        dm_we   = (state_q == ISSUE) && we_q;
        p_done  = (state_q == DONE) && (owner_q == OWN_PIPE);
        l_ack   = (state_q == DONE) && (owner_q == OWN_LDR);
        p_stall = p_req && !p_done && !rst;
    end

    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign p_rdata  = p_rdata_q;
    assign l_rdata  = l_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a LAT=2 instance with a behavioural memory,
// plus a LAT=1 instance sharing the same request inputs.
module tb_dm_arbiter;

    logic        clk, rst;
    logic        p_req, p_we, l_req, l_we;
    logic [7:0]  p_addr, l_addr;
    logic [15:0] p_wdata, l_wdata;

    logic [15:0] p_rdata, l_rdata, dm_wdata, dm_rdata;
    logic        p_stall, l_ack, dm_en, dm_we;
    logic [7:0]  dm_addr;

    logic [15:0] p_rdata1, l_rdata1, dm_wdata1, dm_rdata1;
    logic        p_stall1, l_ack1, dm_en1, dm_we1;
    logic [7:0]  dm_addr1;

    int nvec = 0;
    int nerr = 0;

    dm_arbiter #(.DSIZE(16), .MSIZE(8), .LAT(2)) u0 (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_rdata(l_rdata), .l_ack(l_ack),
        .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    dm_arbiter #(.DSIZE(16), .MSIZE(8), .LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata1), .p_stall(p_stall1),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_rdata(l_rdata1), .l_ack(l_ack1),
        .dm_en(dm_en1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
        .dm_rdata(dm_rdata1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory for u0: read data appears two cycles after the enable cycle.
    logic [15:0] mem [256];
    logic [15:0] sr0, sr1, rd1;
    bit          init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            mem[8'h12] <= 16'hBEEF;
            mem[8'h80] <= 16'h00FF;
            init_done  <= 1'b1;
        end else if (dm_en && dm_we) begin
            mem[dm_addr] <= dm_wdata;
        end
        sr0 <= (dm_en && !dm_we) ? mem[dm_addr] : 16'hA5A5;
        sr1 <= sr0;
    end
    assign dm_rdata = sr1;

    // Memory for u1: single-cycle latency, only address 0x33 is populated.
    always @(posedge clk) begin
        rd1 <= (dm_en1 && !dm_we1 && dm_addr1 == 8'h33) ? 16'hC0DE : 16'h5A5A;
    end
    assign dm_rdata1 = rd1;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; p_req = 1'b1; p_we = 1'b0; p_addr = 8'h00; p_wdata = 16'h0;
        l_req = 1'b0; l_we = 1'b0; l_addr = 8'h00; l_wdata = 16'h0;
        next_cycle;
        next_cycle;
        #1;
        nvec++; if (p_stall !== 1'b0) begin nerr++; $display("FAIL reset_p_stall: got %0d expected 0", p_stall); end
        nvec++; if (dm_en !== 1'b0) begin nerr++; $display("FAIL reset_dm_en: got %0d expected 0", dm_en); end
        nvec++; if (dm_we !== 1'b0) begin nerr++; $display("FAIL reset_dm_we: got %0d expected 0", dm_we); end
        nvec++; if (dm_addr !== 8'h00) begin nerr++; $display("FAIL reset_dm_addr: got %h expected 00", dm_addr); end
        nvec++; if (dm_wdata !== 16'h0) begin nerr++; $display("FAIL reset_dm_wdata: got %h expected 0000", dm_wdata); end
        nvec++; if (p_rdata !== 16'h0) begin nerr++; $display("FAIL reset_p_rdata: got %h expected 0000", p_rdata); end
        nvec++; if (l_rdata !== 16'h0) begin nerr++; $display("FAIL reset_l_rdata: got %h expected 0000", l_rdata); end
        nvec++; if (l_ack !== 1'b0) begin nerr++; $display("FAIL reset_l_ack: got %0d expected 0", l_ack); end
        rst = 1'b0; p_req = 1'b0;
        next_cycle;
    endtask

    task automatic test_pipe_load;
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h12; p_wdata = 16'h0;
        for (int c = 0; c < 5; c++) begin
            #1;
            nvec++; if (p_stall !== (c < 4)) begin nerr++; $display("FAIL pload_stall c%0d: got %0d expected %0d", c, p_stall, (c < 4)); end
            nvec++; if (dm_en !== (c == 1)) begin nerr++; $display("FAIL pload_dm_en c%0d: got %0d expected %0d", c, dm_en, (c == 1)); end
            if (c == 1) begin
                nvec++; if (dm_addr !== 8'h12) begin nerr++; $display("FAIL pload_dm_addr: got %h expected 12", dm_addr); end
                nvec++; if (dm_we !== 1'b0) begin nerr++; $display("FAIL pload_dm_we: got %0d expected 0", dm_we); end
            end
            if (c == 4) begin
                nvec++; if (p_rdata !== 16'hBEEF) begin nerr++; $display("FAIL pload_rdata: got %h expected beef", p_rdata); end
            end
            next_cycle;
        end
        p_req = 1'b0;
        next_cycle;
    endtask

    task automatic test_store_load;
        p_req = 1'b1; p_we = 1'b1; p_addr = 8'h05; p_wdata = 16'h1234;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin p_we = 1'b0; p_wdata = 16'h0; end
            #1;
            nvec++; if (dm_en !== (c == 1 || c == 6)) begin nerr++; $display("FAIL st_ld_dm_en c%0d: got %0d expected %0d", c, dm_en, (c == 1 || c == 6)); end
            nvec++; if (dm_we !== (c == 1)) begin nerr++; $display("FAIL st_ld_dm_we c%0d: got %0d expected %0d", c, dm_we, (c == 1)); end
            nvec++; if (p_stall !== !(c == 4 || c == 9)) begin nerr++; $display("FAIL st_ld_stall c%0d: got %0d expected %0d", c, p_stall, !(c == 4 || c == 9)); end
            if (c == 1) begin
                nvec++; if (dm_wdata !== 16'h1234) begin nerr++; $display("FAIL st_wdata: got %h expected 1234", dm_wdata); end
                nvec++; if (dm_addr !== 8'h05) begin nerr++; $display("FAIL st_addr: got %h expected 05", dm_addr); end
            end
            if (c == 4) begin
                nvec++; if (p_rdata !== 16'hBEEF) begin nerr++; $display("FAIL st_keeps_rdata: got %h expected beef", p_rdata); end
            end
            if (c == 9) begin
                nvec++; if (p_rdata !== 16'h1234) begin nerr++; $display("FAIL ld_after_st: got %h expected 1234", p_rdata); end
            end
            next_cycle;
        end
        p_req = 1'b0;
        next_cycle;
    endtask

    task automatic test_loader_read;
        l_req = 1'b1; l_we = 1'b0; l_addr = 8'h80; l_wdata = 16'h0;
        for (int c = 0; c < 5; c++) begin
            #1;
            nvec++; if (l_ack !== (c == 4)) begin nerr++; $display("FAIL lrd_ack c%0d: got %0d expected %0d", c, l_ack, (c == 4)); end
            nvec++; if (p_stall !== 1'b0) begin nerr++; $display("FAIL lrd_stall c%0d: got %0d expected 0", c, p_stall); end
            nvec++; if (dm_en !== (c == 1)) begin nerr++; $display("FAIL lrd_dm_en c%0d: got %0d expected %0d", c, dm_en, (c == 1)); end
            if (c == 4) begin
                nvec++; if (l_rdata !== 16'h00FF) begin nerr++; $display("FAIL lrd_rdata: got %h expected 00ff", l_rdata); end
                nvec++; if (p_rdata !== 16'h1234) begin nerr++; $display("FAIL lrd_p_rdata: got %h expected 1234", p_rdata); end
            end
            next_cycle;
        end
        l_req = 1'b0;
        next_cycle;
    endtask

    task automatic test_reset_mid_access;
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h12;
        #1;
        nvec++; if (p_stall !== 1'b1) begin nerr++; $display("FAIL rmid_stall0: got %0d expected 1", p_stall); end
        next_cycle;
        #1;
        nvec++; if (dm_en !== 1'b1) begin nerr++; $display("FAIL rmid_issue: got %0d expected 1", dm_en); end
        next_cycle;
        rst = 1'b1;
        #1;
        nvec++; if (p_stall !== 1'b0) begin nerr++; $display("FAIL rmid_stall_in_rst: got %0d expected 0", p_stall); end
        next_cycle;
        #1;
        nvec++; if (dm_en !== 1'b0) begin nerr++; $display("FAIL rmid_dm_en: got %0d expected 0", dm_en); end
        nvec++; if (dm_we !== 1'b0) begin nerr++; $display("FAIL rmid_dm_we: got %0d expected 0", dm_we); end
        nvec++; if (dm_addr !== 8'h00) begin nerr++; $display("FAIL rmid_dm_addr: got %h expected 00", dm_addr); end
        nvec++; if (dm_wdata !== 16'h0) begin nerr++; $display("FAIL rmid_dm_wdata: got %h expected 0000", dm_wdata); end
        nvec++; if (p_rdata !== 16'h0) begin nerr++; $display("FAIL rmid_p_rdata: got %h expected 0000", p_rdata); end
        nvec++; if (l_rdata !== 16'h0) begin nerr++; $display("FAIL rmid_l_rdata: got %h expected 0000", l_rdata); end
        nvec++; if (l_ack !== 1'b0) begin nerr++; $display("FAIL rmid_l_ack: got %0d expected 0", l_ack); end
        nvec++; if (p_stall !== 1'b0) begin nerr++; $display("FAIL rmid_p_stall: got %0d expected 0", p_stall); end
        rst = 1'b0;
        #1;
        nvec++; if (p_stall !== 1'b1) begin nerr++; $display("FAIL rmid_stall_release: got %0d expected 1", p_stall); end
        next_cycle;
        for (int c = 4; c < 8; c++) begin
            #1;
            nvec++; if (dm_en !== (c == 4)) begin nerr++; $display("FAIL rmid_restart_en c%0d: got %0d expected %0d", c, dm_en, (c == 4)); end
            nvec++; if (p_stall !== (c < 7)) begin nerr++; $display("FAIL rmid_restart_stall c%0d: got %0d expected %0d", c, p_stall, (c < 7)); end
            if (c == 4) begin
                nvec++; if (dm_addr !== 8'h12) begin nerr++; $display("FAIL rmid_restart_addr: got %h expected 12", dm_addr); end
            end
            if (c == 7) begin
                nvec++; if (p_rdata !== 16'hBEEF) begin nerr++; $display("FAIL rmid_restart_rdata: got %h expected beef", p_rdata); end
            end
            next_cycle;
        end
        p_req = 1'b0;
        next_cycle;
    endtask

    task automatic test_both_alternate;
        rst = 1'b1;
        next_cycle;
        rst = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h12;
        l_req = 1'b1; l_we = 1'b0; l_addr = 8'h80;
        for (int c = 0; c < 20; c++) begin
            int  k;
            bit  pipe_turn;
            k = c % 5;
            pipe_turn = ((c / 5) % 2) == 0;
            #1;
            nvec++; if (dm_en !== (k == 1)) begin nerr++; $display("FAIL alt_dm_en c%0d: got %0d expected %0d", c, dm_en, (k == 1)); end
            if (k == 1) begin
                nvec++; if (dm_addr !== (pipe_turn ? 8'h12 : 8'h80)) begin nerr++; $display("FAIL alt_grant c%0d: got %h expected %h", c, dm_addr, (pipe_turn ? 8'h12 : 8'h80)); end
            end
            nvec++; if (l_ack !== (k == 4 && !pipe_turn)) begin nerr++; $display("FAIL alt_l_ack c%0d: got %0d expected %0d", c, l_ack, (k == 4 && !pipe_turn)); end
            nvec++; if (p_stall !== !(k == 4 && pipe_turn)) begin nerr++; $display("FAIL alt_stall c%0d: got %0d expected %0d", c, p_stall, !(k == 4 && pipe_turn)); end
            if (c == 4) begin
                nvec++; if (p_rdata !== 16'hBEEF) begin nerr++; $display("FAIL alt_p_rdata: got %h expected beef", p_rdata); end
            end
            if (c == 9) begin
                nvec++; if (l_rdata !== 16'h00FF) begin nerr++; $display("FAIL alt_l_rdata: got %h expected 00ff", l_rdata); end
            end
            next_cycle;
        end
        p_req = 1'b0; l_req = 1'b0;
        next_cycle;
    endtask

    task automatic test_lat1;
        rst = 1'b1;
        next_cycle;
        rst = 1'b0;
        p_req = 1'b1; p_we = 1'b0; p_addr = 8'h33; l_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            nvec++; if (p_stall1 !== (c < 3)) begin nerr++; $display("FAIL lat1_stall c%0d: got %0d expected %0d", c, p_stall1, (c < 3)); end
            nvec++; if (dm_en1 !== (c == 1)) begin nerr++; $display("FAIL lat1_dm_en c%0d: got %0d expected %0d", c, dm_en1, (c == 1)); end
            if (c == 2) begin
                nvec++; if (p_rdata1 !== 16'h0) begin nerr++; $display("FAIL lat1_early_rdata: got %h expected 0000", p_rdata1); end
            end
            if (c == 3) begin
                nvec++; if (p_rdata1 !== 16'hC0DE) begin nerr++; $display("FAIL lat1_rdata: got %h expected c0de", p_rdata1); end
            end
            next_cycle;
        end
        p_req = 1'b0;
        next_cycle;
    endtask

    initial begin
        test_reset;
        test_pipe_load;
        test_store_load;
        test_loader_read;
        test_reset_mid_access;
        test_both_alternate;
        test_lat1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
